fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 151 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin N:1 arbiter driving the write side of an async FIFO.
//            Define ARB_BURST_EN to lock a grant for up to BURST_LEN beats.
// Revision : 1.0
// ============================================================================
module fifo_wr_arbiter #(
  parameter int DSIZE     = 8,
  parameter int NREQ      = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                    wclk,
  input  logic                    wrst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    wfull,
  output logic                    winc,
  output logic [DSIZE-1:0]        wdata,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic [15:0]             xfer_cnt
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || BURST_LEN < 2 || BURST_LEN > 16) begin : g_param_check
    $error("fifo_wr_arbiter: NREQ or BURST_LEN out of range");
  end

  logic [IW-1:0]   rr_ptr_q;
  logic [15:0]     xfer_cnt_q;
  logic [15:0]     xfer_cnt_d;
  logic [NREQ-1:0] rot;
  logic [IW-1:0]   rr_cand;
  logic            rr_found;
  logic [IW-1:0]   cand;
  logic            cand_ok;
  logic            xfer;

  function automatic logic [IW-1:0] ptr_next(input logic [IW-1:0] p);
    return (p == IW'(NREQ - 1)) ? '0 : p + IW'(1);
  endfunction

  // Rotate so bit 0 is rr_ptr; the lowest set bit is the round-robin winner.
  always_comb begin
    rot      = NREQ'({req_valid, req_valid} >> rr_ptr_q);
    rr_found = 1'b0;
    rr_cand  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        rr_found = 1'b1;
        rr_cand  = IW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

`ifdef ARB_BURST_EN
  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t        state_q;
  logic [IW-1:0] lock_q;
  logic [BW-1:0] beat_q;
  logic          burst_done;

  // The release cycle moves no data, so other requesters wait one cycle.
  assign burst_done = (state_q == BURST) &&
                      ((beat_q == BW'(BURST_LEN)) || !req_valid[lock_q]);
  assign cand       = (state_q == BURST) ? lock_q : rr_cand;
  assign cand_ok    = (state_q == BURST) ? !burst_done : rr_found;
  assign xfer       = cand_ok && !wfull && !wrst;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q  <= IDLE;
      lock_q   <= '0;
      beat_q   <= '0;
      rr_ptr_q <= '0;
    end else if (!wfull) begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            state_q <= BURST;
            lock_q  <= cand;
            beat_q  <= BW'(1);
          end
        end
        BURST: begin
          if (burst_done) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            rr_ptr_q <= ptr_next(lock_q);
          end else if (xfer) begin
            beat_q <= beat_q + BW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`else
  logic [IW-1:0] rr_ptr_d;

  assign cand     = rr_cand;
  assign cand_ok  = rr_found;
  assign xfer     = cand_ok && !wfull && !wrst;
  assign rr_ptr_d = xfer ? ptr_next(cand) : rr_ptr_q;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  assign xfer_cnt_d = xfer ? xfer_cnt_q + 16'd1 : xfer_cnt_q;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      xfer_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  always_comb begin
    req_ready = '0;
    wdata     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(cand) == i) begin
        wdata = req_data[i*DSIZE +: DSIZE];
      end
    end
    if (xfer) begin
      req_ready[cand] = 1'b1;
    end
  end

  assign winc     = xfer;
  assign grant_id = (|req_valid) ? cand : '0;
  assign xfer_cnt = xfer_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Randomized self-checking bench for fifo_wr_arbiter against a
//            cycle-level arbitration model (honours ARB_BURST_EN).
// Revision : 1.0
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int DSIZE     = 8;
  localparam int NREQ      = 4;
  localparam int BURST_LEN = 4;
  localparam int IW        = $clog2(NREQ);

  logic                  wclk = 1'b0;
  logic                  wrst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [IW-1:0]         grant_id;
  logic [15:0]           xfer_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: next search start, locked requester (-1 = none), beats, count
  int m_ptr   = 0;
  int m_lock  = -1;
  int m_beats = 0;
  int m_cnt   = 0;

  fifo_wr_arbiter #(
    .DSIZE    (DSIZE),
    .NREQ     (NREQ),
    .BURST_LEN(BURST_LEN)
  ) dut (
    .wclk     (wclk),
    .wrst     (wrst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .wfull    (wfull),
    .winc     (winc),
    .wdata    (wdata),
    .grant_id (grant_id),
    .xfer_cnt (xfer_cnt)
  );

  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, advance model.
  task automatic cycle(input logic [NREQ-1:0] v, input logic f, output int served);
    int      g;
    bit      found;
    bit      rel;
    bit      xf;
    logic [NREQ-1:0] exp_ready;
    @(negedge wclk);
    req_valid = v;
    wfull     = f;
    for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = DSIZE'($urandom);
    #1;
    g = 0; found = 0; rel = 0;
    if (m_lock >= 0) begin
      g     = m_lock;
      rel   = (m_beats == BURST_LEN) || !v[m_lock];
      found = !rel;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (!found && v[(m_ptr + k) % NREQ]) begin
          found = 1;
          g     = (m_ptr + k) % NREQ;
        end
      end
    end
    xf        = found && !f;
    exp_ready = xf ? (NREQ'(1) << g) : '0;
    check("ready", 32'(req_ready), 32'(exp_ready));
    check("winc", 32'(winc), 32'(xf));
    check("grant_id", 32'(grant_id), (|v) ? g : 0);
    check("xfer_cnt", 32'(xfer_cnt), m_cnt);
    if (xf) check("wdata", 32'(wdata), 32'(req_data[g*DSIZE +: DSIZE]));
    served = -1;
    if (!f) begin
      if (m_lock >= 0 && rel) begin
        m_ptr   = (m_lock + 1) % NREQ;
        m_lock  = -1;
        m_beats = 0;
      end else if (xf) begin
        served = g;
        m_cnt  = (m_cnt + 1) % 65536;
        if (m_lock >= 0) begin
          m_beats++;
        end else begin
`ifdef ARB_BURST_EN
          m_lock  = g;
          m_beats = 1;
`else
          m_ptr = (g + 1) % NREQ;
`endif
        end
      end
    end
  endtask

  // Asynchronous reset pulse applied mid-cycle with requesters active.
  task automatic do_reset(input logic [NREQ-1:0] v);
    @(negedge wclk);
    req_valid = v;
    wfull     = 1'b0;
    #2 wrst = 1'b1;
    #1;
    check("rst_winc", 32'(winc), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_cnt", 32'(xfer_cnt), 0);
    @(posedge wclk);
    #1;
    check("rst_winc_edge", 32'(winc), 0);
    @(negedge wclk);
    wrst      = 1'b0;
    req_valid = '0;
    m_ptr = 0; m_lock = -1; m_beats = 0; m_cnt = 0;
  endtask

  initial begin
    int s;
    wrst      = 1'b1;
    req_valid = '0;
    req_data  = '0;
    wfull     = 1'b0;
    do_reset('0);

`ifndef ARB_BURST_EN
    for (int k = 0; k < 5; k++) begin
      cycle(4'b1111, 1'b0, s);
      check("rr_all", s, k % NREQ);
    end
    cycle(4'b0000, 1'b0, s);
    check("idle_no_xfer", s, -1);
    check("cnt_after_5", 32'(xfer_cnt), 5);
    for (int k = 0; k < 4; k++) begin
      cycle(4'b1010, 1'b0, s);
      check("rr_1010", s, (k % 2 == 0) ? 1 : 3);
      check("ready_0_2", 32'(req_ready & 4'b0101), 0);
    end
    cycle(4'b1111, 1'b0, s);
    check("pre_full", s, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(4'b1111, 1'b1, s);
      check("full_winc", 32'(winc), 0);
      check("full_ready", 32'(req_ready), 0);
    end
    cycle(4'b1111, 1'b0, s);
    check("post_full_a", s, 1);
    cycle(4'b1111, 1'b0, s);
    check("post_full_b", s, 2);
`else
    for (int k = 0; k < 9; k++) begin
      cycle(4'b0011, 1'b0, s);
      check("burst_seq", s, (k < 4) ? 0 : (k == 4) ? -1 : 1);
    end
    cycle(4'b0011, 1'b0, s);
    check("burst_rel", s, -1);
    cycle(4'b1100, 1'b0, s);
    check("burst2_a", s, 2);
    cycle(4'b1100, 1'b0, s);
    check("burst2_b", s, 2);
    cycle(4'b1000, 1'b0, s);
    check("drop_rel", s, -1);
    cycle(4'b1000, 1'b0, s);
    check("after_drop", s, 3);
    cycle(4'b1000, 1'b0, s);
    check("beat2", s, 3);
`endif
    do_reset(4'b1111);
    cycle(4'b0110, 1'b0, s);
    check("post_rst_grant", s, 1);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        do_reset(NREQ'($urandom));
      end else begin
        cycle(NREQ'($urandom), ($urandom_range(0, 3) == 0), s);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
